bcd_scan_display: RTL and testbench

//   Time-multiplexed N-digit BCD driver for the common-anode 15-segment display bank.

---
 rtl/bcd_scan_display.sv | 107 ++++++++++
 tb/tb_bcd_scan_display.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Time-multiplexed N-digit BCD driver for a common-anode 15-segment display bank.
// Shadow digits update only on frame boundaries so a scan never mixes two values.
module bcd_scan_display #(
    parameter int N_DIG    = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [4*N_DIG-1:0]   bcd_in,
    input  logic                 lz_blank,
    output logic [14:0]          display,
    output logic [N_DIG-1:0]     digit_sel,
    output logic                 frame_tick
);

    localparam int IDX_W = $clog2(N_DIG);

    logic [DIV_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic                      pend;
    logic [N_DIG-1:0][3:0]     pend_reg;
    logic [N_DIG-1:0][3:0]     shadow;
    logic                      last_cnt;
    logic                      boundary;
    logic [N_DIG-1:0]          blank;
    logic [14:0]               seg_next;

    function automatic logic [14:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 15'h01FF;
            4'd1:    return 15'h7FDB;
            4'd2:    return 15'h127F;
            4'd3:    return 15'h067F;
            4'd4:    return 15'h4C7F;
            4'd5:    return 15'h247F;
            4'd6:    return 15'h207F;
            4'd7:    return 15'h0FFF;
            4'd8:    return 15'h007F;
            4'd9:    return 15'h047F;
            default: return 15'h7FFF;
        endcase
    endfunction

    always_comb begin
        last_cnt = (cnt == DIV_W'(SCAN_DIV - 1));
        boundary = en && last_cnt && (idx == IDX_W'(N_DIG - 1));
    end

    // Walk from the top digit down; a digit blanks only while every digit above it is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank    = '0;
        for (int unsigned k = N_DIG - 1; k >= 1; k--) begin
            all_zero = all_zero && (shadow[k] == 4'd0);
            blank[k] = lz_blank && all_zero;
        end
    end

    always_comb begin
        seg_next = blank[idx] ? '1 : seg_decode(shadow[idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            display    <= '1;
            digit_sel  <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (en) begin
                cnt       <= last_cnt ? '0 : cnt + 1'b1;
                if (last_cnt)
                    idx <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + 1'b1;
                digit_sel <= ~(N_DIG'(1) << idx);
                display   <= seg_next;
            end else begin
                digit_sel <= '1;
                display   <= '1;
            end
        end
    end

    // A load on the boundary itself bypasses pend_reg so it shows from the next digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_reg <= '0;
            shadow   <= '1;
        end else if (load && boundary) begin
            shadow <= bcd_in;
            pend   <= 1'b0;
        end else if (load) begin
            pend_reg <= bcd_in;
            pend     <= 1'b1;
        end else if (boundary && pend) begin
            shadow <= pend_reg;
            pend   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios plus randomized
// traffic against a frame-phase reference model.
module tb_bcd_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FR = ND * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [14:0] display;
    logic [3:0]  digit_sel;
    logic        frame_tick;

    int total = 0;
    int bad = 0;

    // reference model: phase within frame, pending value, shown value, expected outputs
    int unsigned m_t = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_pv = '0;
    logic [15:0] m_sh = 16'hFFFF;
    logic [14:0] m_disp = 15'h7FFF;
    logic [3:0]  m_sel = 4'hF;
    logic        m_tick = 1'b0;

    always #5 clk = ~clk;

    bcd_scan_display #(.N_DIG(ND), .SCAN_DIV(SD), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .bcd_in(bcd_in),
        .lz_blank(lz_blank), .display(display), .digit_sel(digit_sel),
        .frame_tick(frame_tick)
    );

    function automatic logic [14:0] ref_seg(input logic [15:0] v, input int k, input logic lz);
        logic [3:0] d;
        d = v[4*k +: 4];
        if (lz && k >= 1 && (v >> (4*k)) == 0) return 15'h7FFF;
        case (d)
            4'd0: return 15'h01FF;  4'd1: return 15'h7FDB;
            4'd2: return 15'h127F;  4'd3: return 15'h067F;
            4'd4: return 15'h4C7F;  4'd5: return 15'h247F;
            4'd6: return 15'h207F;  4'd7: return 15'h0FFF;
            4'd8: return 15'h007F;  4'd9: return 15'h047F;
            default: return 15'h7FFF;
        endcase
    endfunction

    function automatic int sel_pos(input logic [3:0] s);
        case (s)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    // one clock: advance the model on the edge, then sample 1 time unit later
    task automatic tick();
        logic bnd;
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_pend = 0; m_pv = '0; m_sh = 16'hFFFF;
            m_disp = 15'h7FFF; m_sel = 4'hF; m_tick = 0;
        end else begin
            bnd = en && (m_t == FR - 1);
            if (en) begin
                m_sel  = 4'hF & ~(4'd1 << (m_t / SD));
                m_disp = ref_seg(m_sh, int'(m_t / SD), lz_blank);
            end else begin
                m_sel  = 4'hF;
                m_disp = 15'h7FFF;
            end
            m_tick = bnd;
            if (load && bnd) begin
                m_sh = bcd_in; m_pend = 0;
            end else if (load) begin
                m_pv = bcd_in; m_pend = 1;
            end else if (bnd && m_pend) begin
                m_sh = m_pv; m_pend = 0;
            end
            if (en) m_t = (m_t + 1) % FR;
        end
        #1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bcd_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (frame_tick === 1'b1) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({display, digit_sel, frame_tick} !== {15'h7FFF, 4'hF, 1'b0}) begin
                bad++;
                $display("FAIL reset: got %h/%h/%b want 7fff/f/0", display, digit_sel, frame_tick);
            end
        end
        rst = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_scan();
        int ticks = 0;
        logic [3:0] walk [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (digit_sel !== walk[(i % FR) / SD] || display !== 15'h7FFF ||
                frame_tick !== ((i % FR) == FR - 1)) begin
                bad++;
                $display("FAIL scan_walk[%0d]: got %h/%h/%b want %h/7fff/%b", i, digit_sel,
                         display, frame_tick, walk[(i % FR) / SD], (i % FR) == FR - 1);
            end
            if (frame_tick === 1'b1) ticks++;
        end
        total++;
        if (ticks != 2) begin
            bad++;
            $display("FAIL scan_ticks: got %0d want 2", ticks);
        end
    endtask

    task automatic test_load();
        logic [14:0] exp [4] = '{15'h4C7F, 15'h067F, 15'h127F, 15'h7FDB};
        int p;
        bit armed = 0;
        int n = 0;
        repeat (5) tick();
        pulse_load(16'h1234);
        for (int c = 0; c < 60 && n < 16; c++) begin
            tick();
            total++;
            if (armed) begin
                p = sel_pos(digit_sel);
                if (p < 0 || display !== exp[p]) begin
                    bad++;
                    $display("FAIL load_new: sel %h got %h", digit_sel, display);
                end
                n++;
            end else if (display !== 15'h7FFF) begin
                bad++;
                $display("FAIL load_old_frame: got %h want 7fff", display);
            end
            if (frame_tick === 1'b1) armed = 1;
        end
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL load_window: got %0d frame samples want 16", n);
        end
    endtask

    task automatic test_lz();
        logic [14:0] exp [3][4] = '{'{15'h0FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF},
                                    '{15'h01FF, 15'h7FFF, 15'h7FFF, 15'h7FFF},
                                    '{15'h01FF, 15'h01FF, 15'h01FF, 15'h01FF}};
        logic [15:0] val [3] = '{16'h0007, 16'h0000, 16'h0000};
        bit ok;
        int p;
        for (int s = 0; s < 3; s++) begin
            lz_blank = (s < 2);
            pulse_load(val[s]);
            wait_frame(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL lz_timeout[%0d]: got no frame_tick want one", s);
            end
            for (int i = 0; i < FR; i++) begin
                tick();
                p = sel_pos(digit_sel);
                total++;
                if (p < 0 || display !== exp[s][p]) begin
                    bad++;
                    $display("FAIL lz_digit[%0d]: sel %h got %h", s, digit_sel, display);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [4] = '{15'h007F, 15'h0FFF, 15'h207F, 15'h247F};
        bit seen = 0;
        int p;
        pulse_load(16'h1111);
        pulse_load(16'h9999);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            total++;
            if (display === 15'h7FDB) begin
                bad++;
                $display("FAIL b2b_stale: got %h (digit 1) want never", display);
            end
            if (frame_tick === 1'b1) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL b2b_timeout: got no frame_tick want one");
        end
        for (int i = 0; i < FR; i++) begin
            tick();
            total++;
            if (display !== 15'h047F) begin
                bad++;
                $display("FAIL b2b_last_wins: sel %h got %h want 047f", digit_sel, display);
            end
        end
        for (int i = 0; i < 20 && m_t != FR - 1; i++) tick();
        pulse_load(16'h5678);
        for (int i = 0; i < FR; i++) begin
            tick();
            p = sel_pos(digit_sel);
            total++;
            if (p < 0 || display !== exp[p] || (i == 0 && p != 0)) begin
                bad++;
                $display("FAIL boundary_load[%0d]: sel %h got %h", i, digit_sel, display);
            end
        end
    endtask

    task automatic test_freeze();
        logic [3:0] s;
        for (int i = 0; i < 8 && (m_t % SD) != 1; i++) tick();
        s = digit_sel;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (digit_sel !== 4'hF || display !== 15'h7FFF || frame_tick !== 1'b0) begin
                bad++;
                $display("FAIL freeze: got %h/%h/%b want f/7fff/0", digit_sel, display, frame_tick);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ((i < 3 && digit_sel !== s) || (i == 3 && (digit_sel === s || sel_pos(digit_sel) < 0))) begin
                bad++;
                $display("FAIL resume_dwell[%0d]: got sel %h held %h", i, digit_sel, s);
            end
            total++;
            if ({display, digit_sel, frame_tick} !== {m_disp, m_sel, m_tick}) begin
                bad++;
                $display("FAIL resume_model: got %h/%h/%b want %h/%h/%b", display, digit_sel,
                         frame_tick, m_disp, m_sel, m_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp [4] = '{15'h4C7F, 15'h7FFF, 15'h127F, 15'h7FDB};
        bit ok;
        int p;
        for (int i = 0; i < 20 && m_t != 5; i++) tick();
        pulse_load(16'h4321);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({display, digit_sel, frame_tick} !== {15'h7FFF, 4'hF, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got %h/%h/%b want 7fff/f/0", display, digit_sel, frame_tick);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (display !== 15'h7FFF || sel_pos(digit_sel) < 0) begin
                bad++;
                $display("FAIL reset_discard[%0d]: got %h/%h want 7fff/one-cold", i, display, digit_sel);
            end
        end
        lz_blank = 1'b0;
        pulse_load(16'h12B4);
        wait_frame(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL code_b_timeout: got no frame_tick want one");
        end
        for (int i = 0; i < FR; i++) begin
            tick();
            p = sel_pos(digit_sel);
            total++;
            if (p < 0 || display !== exp[p]) begin
                bad++;
                $display("FAIL code_b: sel %h got %h", digit_sel, display);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(7) != 0);
            load     = ($urandom_range(5) == 0);
            bcd_in   = 16'($urandom);
            lz_blank = 1'($urandom_range(1));
            rst      = ($urandom_range(96) == 0);
            tick();
            total++;
            if ({display, digit_sel, frame_tick} !== {m_disp, m_sel, m_tick}) begin
                bad++;
                $display("FAIL random[%0d]: got %h/%h/%b want %h/%h/%b", i, display, digit_sel,
                         frame_tick, m_disp, m_sel, m_tick);
            end
        end
        load = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_lz();
        test_back_to_back();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
